// File: rtl/pkt_dispatch_rr.sv
`default_nettype none
// ============================================================================
// Module   : pkt_dispatch_rr
// Brief    : Whole-packet round-robin dispatcher (strict or skip-busy) with a
//            tag FIFO that records which queue received each packet.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_dispatch_rr #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_QUEUES         = 4,
    parameter int C_TAG_DEPTH          = 8,
    parameter int C_SKIP_BUSY          = 0,
    localparam int QW = $clog2(C_NUM_QUEUES),
    localparam int CW = $clog2(C_TAG_DEPTH) + 1
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic [C_NUM_QUEUES-1:0]           m_axis_tvalid,
    input  logic [C_NUM_QUEUES-1:0]           m_axis_tready,
    output logic [QW-1:0]                     tag_qid,
    output logic [C_NUM_QUEUES-1:0]           tag_onehot,
    output logic                              tag_valid,
    input  logic                              tag_ready,
    output logic [CW-1:0]                     tag_count
);

    localparam int              AW     = $clog2(C_TAG_DEPTH);
    localparam logic [QW-1:0]   LAST_Q = QW'(C_NUM_QUEUES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FWD  = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [QW-1:0]   r_cur_q, w_cur_q_nxt;
    logic [QW-1:0]   r_lock_q, w_lock_q_nxt;
    logic [QW-1:0]   w_skip_q, w_idx, w_sel;
    logic            w_open, w_xfer, w_push, w_pop;
    logic [QW-1:0]   r_tag_mem [C_TAG_DEPTH];
    logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]   r_count;

    function automatic logic [QW-1:0] f_next_q(input logic [QW-1:0] q);
        return (q == LAST_Q) ? '0 : q + QW'(1);
    endfunction

    // Descending scan so the nearest ready queue after cur_q is written last.
    always_comb begin : p_skip
        w_skip_q = r_cur_q;
        w_idx    = r_cur_q;
        for (int k = C_NUM_QUEUES - 1; k >= 0; k--) begin
            w_idx = QW'((int'(r_cur_q) + k) % C_NUM_QUEUES);
            if (m_axis_tready[w_idx]) begin
                w_skip_q = w_idx;
            end
        end
    end

    always_comb begin : p_sel
        if (r_state == S_FWD) begin
            w_sel = r_lock_q;
        end else if (C_SKIP_BUSY != 0) begin
            w_sel = w_skip_q;
        end else begin
            w_sel = r_cur_q;
        end
    end

    // A new packet may only start when its tag has somewhere to go.
    assign w_open        = aresetn && ((r_state == S_FWD) || (r_count < CW'(C_TAG_DEPTH)));
    assign s_axis_tready = w_open & m_axis_tready[w_sel];
    assign w_xfer        = s_axis_tvalid & s_axis_tready;
    assign w_push        = w_xfer & (r_state == S_IDLE);
    assign w_pop         = tag_valid & tag_ready;

    generate
        for (genvar i = 0; i < C_NUM_QUEUES; i++) begin : g_queue
            assign m_axis_tvalid[i] = s_axis_tvalid & w_open & (w_sel == QW'(i));
            assign tag_onehot[i]    = (tag_qid == QW'(i));
        end
    endgenerate

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tuser = s_axis_tuser;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tlast = s_axis_tlast;

    always_comb begin : p_fsm_nxt
        w_state_nxt  = r_state;
        w_cur_q_nxt  = r_cur_q;
        w_lock_q_nxt = r_lock_q;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (s_axis_tlast) begin
                        w_cur_q_nxt = f_next_q(w_sel);
                    end else begin
                        w_lock_q_nxt = w_sel;
                        w_state_nxt  = S_FWD;
                    end
                end
            end
            S_FWD: begin
                if (w_xfer && s_axis_tlast) begin
                    w_cur_q_nxt = f_next_q(r_lock_q);
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin : p_fsm_reg
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_cur_q  <= '0;
            r_lock_q <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cur_q  <= w_cur_q_nxt;
            r_lock_q <= w_lock_q_nxt;
        end
    end

    always_ff @(posedge axis_clk) begin : p_tag_ctl
        if (!aresetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge axis_clk) begin : p_tag_mem
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_sel;
        end
    end

    // Storage is not reset, so the head is forced to queue 0 while empty.
    assign tag_valid = (r_count != '0);
    assign tag_qid   = tag_valid ? r_tag_mem[r_rd_ptr] : '0;
    assign tag_count = r_count;

endmodule
`default_nettype wire

// File: doc/pkt_dispatch_rr.md
# pkt_dispatch_rr

Parametrised packet dispatcher between the ingress AXI-Stream and the per-queue packet caches, ahead of the parser's PHV output. Whole packets are steered to one of C_NUM_QUEUES output queues in round-robin order, either strict or skip-busy. The chosen queue index is recorded in a tag FIFO at packet start, so the PHV consumer tags each header vector with the queue that actually holds its payload. Queue selection and PHV tagging cannot drift apart under back-pressure.

## Interface
Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width; tkeep is /8.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- C_NUM_QUEUES, 4, number of output queues, 2..16.
- C_TAG_DEPTH, 8, tag FIFO entries, power of two, >= 2.
- C_SKIP_BUSY, 0, 0 = strict round-robin, 1 = skip queues not ready at packet start.
- Derived localparam QW = clog2(C_NUM_QUEUES).

Ports:
- axis_clk  in  1  clock.
- aresetn  in  1  synchronous, active-low reset.
- s_axis_tdata / tuser / tkeep  in  DATA / TUSER / DATA/8  ingress beat.
- s_axis_tvalid, s_axis_tlast  in  1  ingress valid, last beat.
- s_axis_tready  out  1  ingress ready.
- m_axis_tdata / tuser / tkeep / tlast  out  same widths  shared egress bus, direct copy of ingress.
- m_axis_tvalid  out  C_NUM_QUEUES  per-queue valid.
- m_axis_tready  in  C_NUM_QUEUES  per-queue ready.
- tag_qid  out  QW  head-of-FIFO queue index.
- tag_onehot  out  C_NUM_QUEUES  one-hot of tag_qid.
- tag_valid  out  1  FIFO non-empty.
- tag_ready  in  1  consumer pops head.
- tag_count  out  clog2(C_TAG_DEPTH)+1  FIFO occupancy.

## Operation
- Registers:
  - state: IDLE or FWD.
  - cur_q: next round-robin queue.
  - lock_q: queue owning the current packet.
  - Tag FIFO: rd_ptr, wr_ptr, count.
- Selection `sel`:
  - In FWD: sel = lock_q.
  - In IDLE, strict mode: sel = cur_q.
  - In IDLE, skip mode: sel = first index i, searched circularly from cur_q, with m_axis_tready[i] = 1. If none is ready, sel = cur_q.
  - sel is re-evaluated every IDLE cycle.
- Gating: `open` = (state == FWD) or (count < C_TAG_DEPTH).
- Handshake signals:
  - m_axis_tvalid[i] = s_axis_tvalid & open & (i == sel). Valid never depends on the selected ready.
  - s_axis_tready = open & m_axis_tready[sel].
  - A beat transfers when s_axis_tvalid & s_axis_tready.
- IDLE with a beat transfer:
  - Push sel into the tag FIFO.
  - If not tlast: lock_q <= sel, state <= FWD.
  - If tlast (single-beat packet): cur_q <= sel+1, wrapping at C_NUM_QUEUES, and stay in IDLE.
- FWD with a beat transfer:
  - No selection change mid-packet, even if lock_q deasserts ready. The beat stalls instead.
  - On tlast: cur_q <= lock_q+1 (wrap), state <= IDLE.
- Tag FIFO:
  - Push only on first-beat transfers. Push is impossible when full because `open` blocks it.
  - Pop on tag_valid & tag_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop on empty is ignored.
  - Pointers wrap modulo C_TAG_DEPTH.
- Wrap: cur_q after C_NUM_QUEUES-1 is 0, including non-power-of-two queue counts.

## Timing
- Data path is combinational: zero latency from ingress to egress; ready and valid pass through in the same cycle.
- Tag latency: an entry is visible on tag_valid/tag_qid the cycle after the first-beat transfer. tag_count updates on the same edge.
- Back-to-back packets are supported with no idle cycle: after a tlast transfer, the next cycle's first beat uses the new cur_q.
- Reset values:
  - state = IDLE, cur_q = 0, lock_q = 0.
  - Tag FIFO empty: tag_valid = 0, tag_count = 0, tag_qid = 0, tag_onehot = 1.
  - While aresetn = 0, s_axis_tready = 0 and m_axis_tvalid = 0.
- Reset mid-packet: the partial packet is abandoned and pending tags are discarded. The first packet after reset goes to queue 0 in strict mode.

## Test plan
- Round-robin order and wrap (strict, N=3, all ready): five 3-beat packets -> go to queues 0,1,2,0,1; tags 0,1,2,0,1; s_axis_tready stays 1 throughout; no gap between packets.
- Strict stall (N=4): m_axis_tready[1] = 0 for 5 cycles at packet 2's first beat -> s_axis_tready = 0 for those 5 cycles; m_axis_tvalid = 0010 and no other queue asserts valid; the packet then lands in queue 1 with tag 1.
- Skip-busy selection (C_SKIP_BUSY=1, N=4): cur_q = 1 and m_axis_tready = 1101 -> packet goes to queue 2, tag 2, cur_q becomes 3.
- Skip-busy with no ready queue: m_axis_tready = 0000 in IDLE -> stall with sel = cur_q; the packet goes to the first queue to assert ready, searched circularly from cur_q.
- Mid-packet lock (skip mode): queue 2 drops ready on beat 2 of 4 while queue 3 is ready -> beats stall and all remaining beats still go to queue 2.
- Tag FIFO full: depth 8, tag_ready = 0, eight 1-beat packets -> tag_count = 8 and the 9th packet is blocked (s_axis_tready = 0). Pulse tag_ready for one cycle -> the 9th packet is accepted the next cycle and tag_count returns to 8.
- Simultaneous push and pop: tag_count is unchanged and the head advances.
- Reset mid-packet: assert reset on beat 2 of a 4-beat packet to queue 3 -> tag_valid = 0, tag_count = 0; the next packet goes to queue 0.
